// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/response and the
// decode-side handshake. The controller uses the master view; memory and
// decode models use the slave view.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. Sequences one instruction-memory read at a
// time, hands the result to decode, and steers the external PC register
// (hold, advance by 4, or load a redirect target).
//
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN
//   defined   : a non-trap redirect whose target has bits[1:0] != 0 loads
//               MISALIGN_VEC instead and pulses misalign for that cycle.
//   undefined : redirect targets are loaded with bits[1:0] cleared and
//               misalign stays 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | first cycle after reset, no request, redirects ignored
// FETCH   | request outstanding at pc_cur
// DELIVER | instruction held for decode until accepted or redirected
// DRAIN   | request for a stale address still outstanding; data discarded
module fetch_ctrl #(
  parameter logic [31:0] MISALIGN_VEC = 32'h0000_0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_cur,
  output logic              pc_load,
  output logic [31:0]       pc_in,
  input  logic              trap_req,
  input  logic [31:0]       trap_vec,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp_req,
  input  logic [31:0]       jmp_target,
  output logic              misalign,
  fetch_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] drain_addr;

  logic        redir_any;
  logic        redir_act;
  logic [31:0] redir_tgt;
  logic        bad_align;
  logic [31:0] legal_tgt;
  logic [31:0] load_tgt;

  // Redirect arbitration: trap beats branch beats jump.
  always_comb begin
    redir_any = trap_req | br_taken | jmp_req;
    if (trap_req) begin
      redir_tgt = trap_vec;
    end else if (br_taken) begin
      redir_tgt = br_target;
    end else begin
      redir_tgt = jmp_target;
    end
    // A redirect only takes effect once the controller is running.
    redir_act = redir_any && (state != IDLE) && !rst;
  end

  // Target legalisation; trap vectors are trusted in the trapping build.
  always_comb begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    bad_align = redir_act && !trap_req && (redir_tgt[1:0] != 2'b00);
    legal_tgt = redir_tgt;
`else
    bad_align = 1'b0;
    legal_tgt = redir_tgt & 32'hFFFF_FFFC;
`endif
    load_tgt = bad_align ? MISALIGN_VEC : legal_tgt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (redir_any) begin
          // With the ack in hand the stale data is simply dropped; without
          // it the old request must be waited out before re-fetching.
          state_nxt = bus.imem_ack ? FETCH : DRAIN;
        end else if (bus.imem_ack) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        if (redir_any || bus.instr_ready) begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: memory request, decode valid and PC steering.
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.imem_addr   = pc_cur;
    bus.instr_valid = 1'b0;
    pc_load         = 1'b1;
    pc_in           = pc_cur;
    misalign        = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.imem_req = 1'b1;
        end
        DELIVER: begin
          bus.instr_valid = 1'b1;
          // Only a clean accept lets the PC register step to the next word.
          if (bus.instr_ready && !redir_any) begin
            pc_load = 1'b0;
          end
        end
        DRAIN: begin
          bus.imem_req  = 1'b1;
          bus.imem_addr = drain_addr;
        end
        default: begin
        end
      endcase
      if (redir_act) begin
        pc_in    = load_tgt;
        misalign = bad_align;
      end
    end
  end

  // Captured instruction and the address of a request being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instr    <= 32'h0;
      bus.instr_pc <= 32'h0;
      drain_addr   <= 32'h0;
    end else if (state == FETCH) begin
      if (bus.imem_ack && !redir_any) begin
        bus.instr    <= bus.imem_rdata;
        bus.instr_pc <= pc_cur;
      end else if (redir_any && !bus.imem_ack) begin
        drain_addr <= pc_cur;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level model that owns
// the PC register and the memory/decode side.
module tb_fetch_ctrl;

  localparam logic [31:0] MISALIGN_VEC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_load;
  logic [31:0] pc_in;
  logic        trap_req, br_taken, jmp_req;
  logic [31:0] trap_vec, br_target, jmp_target;
  logic        misalign;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.MISALIGN_VEC(MISALIGN_VEC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .trap_req   (trap_req),
    .trap_vec   (trap_vec),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_target (jmp_target),
    .misalign   (misalign),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: running flag, held-instruction flag, draining flag, plus the
  // values the controller is expected to be holding.
  logic        m_running;
  logic        m_held;
  logic        m_draining;
  logic [31:0] m_instr, m_ipc, m_drain_addr, m_pc;

  logic        e_redirect;
  logic        e_req, e_valid, e_load, e_mis;
  logic [31:0] e_addr, e_pc_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for the current inputs and model contents.
  task automatic expect_now();
    logic [31:0] winner;
    logic        from_trap;
    from_trap  = trap_req;
    winner     = trap_req ? trap_vec : (br_taken ? br_target : jmp_target);
    e_redirect = !rst && m_running && (trap_req || br_taken || jmp_req);
    e_req      = !rst && m_running && !m_held;
    e_addr     = m_draining ? m_drain_addr : m_pc;
    e_valid    = !rst && m_held;
    e_load     = !(!rst && m_held && bus.instr_ready && !e_redirect);
    e_mis      = 1'b0;
    e_pc_in    = m_pc;
    if (e_redirect) begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      if (!from_trap && (winner % 4) != 0) begin
        e_pc_in = MISALIGN_VEC;
        e_mis   = 1'b1;
      end else begin
        e_pc_in = winner;
      end
`else
      e_pc_in = winner - (winner % 4);
`endif
    end
  endtask

  task automatic model_update();
    logic [31:0] next_pc;
    expect_now();
    if (rst) begin
      m_running = 1'b0; m_held = 1'b0; m_draining = 1'b0;
      m_instr = 32'h0; m_ipc = 32'h0; m_drain_addr = 32'h0;
    end else begin
      next_pc = e_load ? e_pc_in : m_pc + 32'd4;
      if (!m_running) begin
        m_running = 1'b1;
      end else if (m_held) begin
        if (e_redirect || bus.instr_ready) m_held = 1'b0;
      end else if (m_draining) begin
        if (bus.imem_ack) m_draining = 1'b0;
      end else if (e_redirect && !bus.imem_ack) begin
        m_draining   = 1'b1;
        m_drain_addr = m_pc;
      end else if (bus.imem_ack && !e_redirect) begin
        m_held  = 1'b1;
        m_instr = bus.imem_rdata;
        m_ipc   = m_pc;
      end
      m_pc = next_pc;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    expect_now();
    chk("imem_req", bus.imem_req, e_req);
    if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
    chk("instr_valid", bus.instr_valid, e_valid);
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("pc_load", pc_load, e_load);
    if (e_load) chk("pc_in", pc_in, e_pc_in);
    chk("misalign", misalign, e_mis);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    pc_cur = m_pc;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    trap_req = 1'b0; br_taken = 1'b0; jmp_req = 1'b0;
    trap_vec = 32'h0; br_target = 32'h0; jmp_target = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    m_running = 1'b0; m_held = 1'b0; m_draining = 1'b0;
    m_instr = 32'h0; m_ipc = 32'h0; m_drain_addr = 32'h0;
    m_pc = 32'h100;
    pc_cur = m_pc;

    // Reset, two cycles.
    tick();
    settle();
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_pc_load", pc_load, 1'b1);
    chk("rst_pc_in", pc_in, 32'h100);
    chk("rst_instr", bus.instr, 32'h0);
    tick();

    // First fetch at 0x100, ack one cycle late, decode ready.
    rst = 1'b0;
    settle();
    chk("idle_req", bus.imem_req, 1'b0);
    tick();
    settle();
    chk("first_addr", bus.imem_addr, 32'h100);
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_0001;
    step();
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    settle();
    chk("first_ipc", bus.instr_pc, 32'h100);
    chk("accept_pc_load", pc_load, 1'b0);
    tick();

    // Decode stalls three cycles on the instruction at 0x104.
    bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_0002;
    step();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_valid", bus.instr_valid, 1'b1);
      chk("stall_instr", bus.instr, 32'hDEAD_0002);
      chk("stall_pc_load", pc_load, 1'b1);
      chk("stall_pc_in", pc_in, 32'h104);
      tick();
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;

    // All three redirect sources at once while fetching 0x108, no ack.
    trap_req = 1'b1; br_taken = 1'b1; jmp_req = 1'b1;
    trap_vec = 32'h4; br_target = 32'h80; jmp_target = 32'hC0;
    settle();
    chk("prio_pc_in", pc_in, 32'h4);
    chk("prio_pc_load", pc_load, 1'b1);
    tick();
    trap_req = 1'b0; br_taken = 1'b0; jmp_req = 1'b0;
    settle();
    chk("drain_addr_prio", bus.imem_addr, 32'h108);
    tick();
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;

    // Branch to 0x200 while fetching 0x4; ack arrives two cycles later.
    br_taken = 1'b1; br_target = 32'h200;
    step();
    br_taken = 1'b0;
    settle();
    chk("drain_hold1", bus.imem_addr, 32'h4);
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("drain_hold2", bus.imem_addr, 32'h4);
    tick();
    bus.imem_ack = 1'b0;
    settle();
    chk("post_drain_addr", bus.imem_addr, 32'h200);
    chk("post_drain_valid", bus.instr_valid, 1'b0);
    tick();

    // Misaligned jump coinciding with an ack.
    jmp_req = 1'b1; jmp_target = 32'h302; bus.imem_ack = 1'b1;
    settle();
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    chk("mis_pc_in", pc_in, MISALIGN_VEC);
    chk("mis_pulse", misalign, 1'b1);
`else
    chk("mis_pc_in", pc_in, 32'h300);
    chk("mis_pulse", misalign, 1'b0);
`endif
    tick();
    jmp_req = 1'b0; bus.imem_ack = 1'b0;
    settle();
    chk("mis_clear", misalign, 1'b0);
    tick();

    // Reset while delivering; a stray ack in IDLE must be ignored.
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ack = 1'b0;
    settle();
    chk("pre_rst_valid", bus.instr_valid, 1'b1);
    tick();
    rst = 1'b1;
    settle();
    chk("rst_deliver_valid", bus.instr_valid, 1'b0);
    chk("rst_deliver_req", bus.imem_req, 1'b0);
    tick();
    rst = 1'b0; bus.imem_ack = 1'b1;
    settle();
    chk("idle_ack_req", bus.imem_req, 1'b0);
    tick();
    bus.imem_ack = 1'b0;
    settle();
    chk("after_idle_valid", bus.instr_valid, 1'b0);
    chk("after_idle_req", bus.imem_req, 1'b1);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      trap_req = ($urandom_range(0, 15) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      jmp_req  = ($urandom_range(0, 11) == 0);
      r = $urandom; r[1:0] = 2'b00; trap_vec = r;
      r = $urandom; if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00; br_target = r;
      r = $urandom; if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00; jmp_target = r;
      bus.imem_ack    = !rst && m_running && !m_held && ($urandom_range(0, 1) == 1);
      bus.imem_rdata  = $urandom;
      bus.instr_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter MISALIGN_VEC, default 32'h0000_0010, redirect target used on misaligned redirect (see REQ-030).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_cur  input  32  current PC from PC register output.
REQ-005 pc_load  output  1  PC register load strobe; 0 lets PC register advance by 4.
REQ-006 pc_in  output  32  value loaded into PC register when pc_load=1.
REQ-007 trap_req / trap_vec  input  1 / 32  trap redirect request and target.
REQ-008 br_taken / br_target  input  1 / 32  taken-branch redirect and target.
REQ-009 jmp_req / jmp_target  input  1 / 32  jump redirect and target.
REQ-010 imem_req / imem_addr  output  1 / 32  instruction memory request and address.
REQ-011 imem_ack / imem_rdata  input  1 / 32  memory completion and read data, valid same cycle.
REQ-012 instr_valid / instr / instr_pc  output  1 / 32 / 32  fetched instruction to decode.
REQ-013 instr_ready  input  1  decode accepts instr when instr_valid=1.
REQ-014 misalign  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-015 FSM states: IDLE, FETCH, DELIVER, DRAIN; state, instr, instr_pc, drain address registered.
REQ-016 Redirect active when any of trap_req, br_taken, jmp_req is 1; priority trap > branch > jump; target = winner's target.
REQ-017 Redirect in any state except IDLE: pc_load=1, pc_in=target that cycle; redirects in IDLE ignored.
REQ-018 No redirect: pc_load=1, pc_in=pc_cur (hold) in every cycle except REQ-022's advance cycle.
REQ-019 IDLE: imem_req=0, instr_valid=0; next state FETCH unconditionally.
REQ-020 FETCH: imem_req=1, imem_addr=pc_cur; on imem_ack without redirect, capture instr=imem_rdata, instr_pc=pc_cur, go DELIVER.
REQ-021 FETCH, redirect without imem_ack: latch pc_cur as drain address, go DRAIN; redirect with imem_ack: discard data, stay FETCH.
REQ-022 DELIVER: instr_valid=1; on instr_ready without redirect: pc_load=0 (PC+4), go FETCH; otherwise hold instr and state.
REQ-023 DELIVER, redirect: go FETCH; if instr_ready also 1, instruction counts as consumed, else dropped.
REQ-024 DRAIN: imem_req=1, imem_addr=drain address (stable); on imem_ack discard data, go FETCH; further redirects still load pc_in, state unchanged.
REQ-025 imem_req, once asserted, stays asserted with unchanged imem_addr until imem_ack; at most one outstanding request.
REQ-026 instr_valid, once asserted, stays asserted with unchanged instr/instr_pc until instr_ready or redirect.
REQ-027 Latency: no-redirect, zero-wait memory, instr_ready=1 gives one instruction every 2 cycles.

Reset
REQ-028 While rst=1: state=IDLE, imem_req=0, instr_valid=0, misalign=0, pc_load=1, pc_in=pc_cur, instr=0, instr_pc=0, drain address=0.
REQ-029 Reset mid-transaction abandons outstanding request and instruction; imem_ack in IDLE ignored; memory shares rst.

Configuration
REQ-030 FETCH_CTRL_MISALIGN_TRAP_EN defined: non-trap winning target with bits[1:0]!=0 loads MISALIGN_VEC instead, misalign=1 that cycle; trap_vec never checked.
REQ-031 FETCH_CTRL_MISALIGN_TRAP_EN undefined: pc_in=target with bits[1:0] forced 0; misalign tied 0.

Verification
REQ-032 rst 2 cycles, pc_cur=32'h100, ack after 1 cycle, ready=1 -> imem_addr=32'h100, instr_pc=32'h100, pc_load=0 on accept cycle.
REQ-033 In DELIVER instr_ready=0 for 3 cycles -> instr_valid=1, instr stable, pc_load=1 pc_in=pc_cur each cycle.
REQ-034 trap_req, br_taken, jmp_req together, vec 32'h4/32'h80/32'hC0 -> pc_in=32'h4 only.
REQ-035 br_taken target 32'h200 in FETCH, no ack; ack 2 cycles later -> old imem_addr held, data discarded, next imem_addr=32'h200.
REQ-036 Macro defined, jmp_target 32'h302 -> pc_in=MISALIGN_VEC, misalign pulse; undefined -> pc_in=32'h300, misalign=0.
REQ-037 rst asserted in DELIVER -> next cycle instr_valid=0, imem_req=0, state IDLE, subsequent ack ignored.
